// File: rtl/fetch_sequencer.sv
// Program counter / fetch stage: captures instruction words from memory, hands them to
// execute with a valid/ready handshake and applies branch, HALT and range-fault decisions.
module fetch_sequencer #(
    parameter int          PROG_DEPTH  = 128,
    parameter logic [3:0]  HALT_OPCODE = 4'b1110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  programSelect,
    input  logic [15:0] instruction,
    input  logic        execReady,
    input  logic        branchTaken,
    input  logic [7:0]  branchTarget,
    output logic [7:0]  address,
    output logic [15:0] instrReg,
    output logic        instrValid,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retiredCount
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    localparam logic [8:0] PROG_LIMIT = 9'(PROG_DEPTH);

    logic [1:0]  stateReg, stateNext;
    logic [7:0]  addressReg, addressNext;
    logic [15:0] instrRegReg, instrRegNext;
    logic        haltedReg, haltedNext;
    logic        faultReg, faultNext;
    logic [15:0] countReg, countNext;
    logic [7:0]  prevSelReg;
    logic [15:0] countInc;
    logic [8:0]  nextPc;

    assign countInc = (countReg == 16'hFFFF) ? countReg : countReg + 16'd1;
    // 9-bit so that a fall-through from 8'hFF is caught as out of range instead of wrapping
    assign nextPc   = branchTaken ? {1'b0, branchTarget} : {1'b0, addressReg} + 9'd1;

    always_comb begin
        stateNext    = stateReg;
        addressNext  = addressReg;
        instrRegNext = instrRegReg;
        haltedNext   = haltedReg;
        faultNext    = faultReg;
        countNext    = countReg;

        if (programSelect != prevSelReg) begin
            stateNext    = FETCH;
            addressNext  = 8'd0;
            instrRegNext = 16'd0;
            haltedNext   = 1'b0;
            faultNext    = 1'b0;
            countNext    = 16'd0;
        end else begin
            case (stateReg)
                FETCH: begin
                    if (enable) begin
                        instrRegNext = instruction;
                        if (instruction[15:12] == HALT_OPCODE) begin
                            stateNext  = HALT;
                            haltedNext = 1'b1;
                            countNext  = countInc;
                        end else begin
                            stateNext = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (execReady) begin
                        countNext = countInc;
                        if (nextPc >= PROG_LIMIT) begin
                            stateNext  = HALT;
                            haltedNext = 1'b1;
                            faultNext  = 1'b1;
                        end else begin
                            addressNext = nextPc[7:0];
                            stateNext   = FETCH;
                        end
                    end
                end
                HALT: begin
                    stateNext = HALT;
                end
                default: begin
                    stateNext = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        prevSelReg <= programSelect;
        if (reset) begin
            stateReg    <= FETCH;
            addressReg  <= 8'd0;
            instrRegReg <= 16'd0;
            haltedReg   <= 1'b0;
            faultReg    <= 1'b0;
            countReg    <= 16'd0;
        end else begin
            stateReg    <= stateNext;
            addressReg  <= addressNext;
            instrRegReg <= instrRegNext;
            haltedReg   <= haltedNext;
            faultReg    <= faultNext;
            countReg    <= countNext;
        end
    end

    assign address      = addressReg;
    assign instrReg     = instrRegReg;
    assign instrValid   = (stateReg == ISSUE);
    assign halted       = haltedReg;
    assign fault        = faultReg;
    assign retiredCount = countReg;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch stage that drives the address input of the instruction memory and captures the returned 16-bit instruction into an instruction register.
- Hands each instruction to the execute stage with a valid/ready handshake, then applies the execute stage's branch decision.
- Detects HALT (opcode 4'b1110) and out-of-range PCs, and restarts the program at address 0 whenever the program-select switches change.

Parameters:
PROG_DEPTH, 128, number of valid instruction words per program; legal PC range is 0..PROG_DEPTH-1
HALT_OPCODE, 4'b1110, opcode value in instr[15:12] that stops fetching

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  run permission; gates only the FETCH->ISSUE transition
programSelect  input  8  program-select switches; also routed to instruction memory
instruction  input  16  instruction word from memory; combinational function of address
execReady  input  1  execute stage accepts/retires instrReg this cycle
branchTaken  input  1  sampled only when execReady=1; next PC = branchTarget
branchTarget  input  8  absolute branch destination
address  output  8  current PC, drives instruction memory
instrReg  output  16  captured instruction
instrValid  output  1  instrReg valid for execute (high only in ISSUE)
halted  output  1  sequencer stopped (HALT opcode or fault)
fault  output  1  stopped because of an out-of-range PC
retiredCount  output  16  instructions retired since last restart, saturating at 16'hFFFF

Behaviour:
- Reset values:
  - Registers: address=0, instrReg=0, halted=0, fault=0, retiredCount=0, state=FETCH.
  - Outputs: instrValid=0 (derived from state).
  - prevSel<=programSelect, so reset never triggers a spurious restart.
- Priority per cycle: reset > programSelect change > state machine.
- Restart on programSelect change:
  - Trigger: programSelect != prevSel.
  - Next cycle: address=0, instrReg=0, halted=0, fault=0, retiredCount=0, state=FETCH, prevSel updated.
  - Applies in every state, including HALT.
  - Any execReady in the same cycle is ignored.
- State FETCH:
  - instrValid=0.
  - If enable=0: hold all registers.
  - If enable=1: instrReg<=instruction.
    - If instruction[15:12]==HALT_OPCODE: go to HALT, set halted=1, increment retiredCount (saturating). address holds at the HALT location.
    - Otherwise go to ISSUE.
- State ISSUE:
  - instrValid=1; instrReg and address stable.
  - If execReady=0: hold indefinitely. enable has no effect here.
  - If execReady=1:
    - Increment retiredCount (saturating).
    - nextPC = branchTaken ? branchTarget : address+1, computed in 9 bits so 8'hFF+1 does not wrap.
    - If nextPC >= PROG_DEPTH: go to HALT with halted=1, fault=1, address unchanged.
    - Otherwise address<=nextPC and go to FETCH.
- State HALT:
  - instrValid=0; all registers hold.
  - Exit only via reset or programSelect change.
- Latency:
  - Minimum 2 cycles per instruction (FETCH, then ISSUE with execReady=1).
  - address updates on the same edge that retires the instruction.
- branchTaken and branchTarget are don't-care when execReady=0.
- No combinational path from instruction to any output except through instrReg.

Test Plan:
- Sequential fetch: reset, programSelect=8'h01, enable=1, execReady=1 always, memory returns non-HALT words -> address steps 0,1,2,3 every 2 cycles; instrValid pulses 1 cycle each; retiredCount=4 after 8 cycles following reset release.
- Branch: at address=5 in ISSUE, drive execReady=1, branchTaken=1, branchTarget=8'h02 -> next address=8'h02; instrReg reloads from 0x02 one cycle later. Repeat with branchTaken=1, execReady=0 for 3 cycles -> address stays 5.
- HALT: word 16'hE000 at address 5, addresses 0-4 retire normally -> halted=1 on the cycle after FETCH of address 5; address holds 5; instrValid=0; retiredCount=6; fault=0; further execReady pulses change nothing.
- Range fault: run to address 8'h7F, retire with branchTaken=0 -> halted=1, fault=1, address=8'h7F. Separately, branchTarget=8'h80 from address 3 -> fault=1, address=3.
- Restart: programSelect 8'h01->8'h04 while in ISSUE with execReady=1 -> next cycle address=0, instrValid=0, retiredCount=0, no retire counted. Change programSelect while halted with fault=1 -> halted=0, fault=0, fetch resumes at 0.
- Stall/enable: hold execReady=0 for 10 cycles in ISSUE -> instrValid=1, instrReg and address constant throughout. Deassert enable in FETCH for 5 cycles -> instrValid stays 0 and address stays constant; assert enable -> ISSUE on the next cycle.
